// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op encodings and FSM state codes for the multiply/divide unit
package mdu_pkg;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef logic [1:0] mdu_state_t;
   localparam mdu_state_t ST_IDLE = 2'd0;
   localparam mdu_state_t ST_PREP = 2'd1;
   localparam mdu_state_t ST_RUN  = 2'd2;
   localparam mdu_state_t ST_FIX  = 2'd3;

   function automatic logic op_is_iter(input logic [2:0] o);
      return (o == OP_MULT) || (o == OP_MULTU) || (o == OP_DIV) || (o == OP_DIVU);
   endfunction

   function automatic logic op_is_signed(input logic [2:0] o);
      return (o == OP_MULT) || (o == OP_DIV);
   endfunction

endpackage

// File: rtl/hilo_muldiv_unit_core.sv
// rtl/hilo_muldiv_unit_core.sv - magnitude shift-add multiply / restoring divide datapath
// Mul leaves the product in acc; div leaves remainder in acc[hi] and quotient in acc[lo].
module mdu_iter_core #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               step,
   input  logic               div_mode,
   input  logic [WIDTH-1:0]   opa,
   input  logic [WIDTH-1:0]   opb,
   output logic [2*WIDTH-1:0] acc
);

   logic [WIDTH-1:0]   opnd;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] acc_next;

   always_comb begin
      sum      = '0;
      diff     = '0;
      acc_next = acc;
      if (div_mode) begin
         // Partial remainder shifted left can reach WIDTH+1 bits before the trial subtract
         diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
         if (!diff[WIDTH])
            acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         else
            acc_next = {acc[2*WIDTH-2:0], 1'b0};
      end else begin
         sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
         acc_next = {sum, acc[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc  <= '0;
         opnd <= '0;
      end else if (load) begin
         acc  <= {{WIDTH{1'b0}}, opa};
         opnd <= opb;
      end else if (step) begin
         acc  <= acc_next;
      end
   end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - multi-cycle MULT/MULTU/DIV/DIVU with HI/LO, MTHI/MTLO and flush
import mdu_pkg::*;

module hilo_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   mdu_state_t         state;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH-1:0]   raw_a;
   logic               is_div;
   logic               div_zero;
   logic               neg_q;
   logic               neg_r;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;
   logic               sgn;

   assign sgn = op_is_signed(op);

   mdu_iter_core #(.WIDTH(WIDTH)) u_core (
      .clk      (clk),
      .rst      (rst),
      .load     (state == ST_PREP),
      .step     ((state == ST_RUN) && !flush),
      .div_mode (is_div),
      .opa      (mag_a),
      .opb      (mag_b),
      .acc      (acc)
   );

   // neg_q doubles as the product sign for multiplies
   assign prod = neg_q ? -acc : acc;
   assign quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         mag_a    <= '0;
         mag_b    <= '0;
         raw_a    <= '0;
         is_div   <= 1'b0;
         div_zero <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
      end else if (flush) begin
         state <= ST_IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start && op_is_iter(op)) begin
                  mag_a    <= (sgn && a[WIDTH-1]) ? -a : a;
                  mag_b    <= (sgn && b[WIDTH-1]) ? -b : b;
                  raw_a    <= a;
                  is_div   <= (op == OP_DIV) || (op == OP_DIVU);
                  div_zero <= (b == '0);
                  neg_q    <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_r    <= sgn && a[WIDTH-1];
                  busy     <= 1'b1;
                  state    <= ST_PREP;
               end else if (start && (op == OP_MTHI)) begin
                  hi   <= a;
                  done <= 1'b1;
               end else if (start && (op == OP_MTLO)) begin
                  lo   <= a;
                  done <= 1'b1;
               end
            end
            ST_PREP: begin
               cnt   <= '0;
               state <= ST_RUN;
            end
            ST_RUN: begin
               if (cnt == CW'(WIDTH-1)) begin
                  cnt   <= '0;
                  state <= ST_FIX;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_FIX: begin
               if (is_div && div_zero) begin
                  lo <= '1;
                  hi <= raw_a;
               end else if (is_div) begin
                  lo <= quo;
                  hi <= rem;
               end else begin
                  {hi, lo} <= prod;
               end
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - randomized + directed check of hilo_muldiv_unit against a transaction model
module tb_hilo_muldiv_unit;
   import mdu_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         flush = 1'b0;
   logic [2:0]   op = 3'd0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int total = 0;
   int bad = 0;

   // transaction-level model state
   logic [W-1:0] m_hi = '0;
   logic [W-1:0] m_lo = '0;
   logic [W-1:0] p_hi = '0;
   logic [W-1:0] p_lo = '0;
   logic         p_valid = 1'b0;
   logic         m_done = 1'b0;
   longint       edge_n = 0;
   longint       p_edge = 0;

   hilo_muldiv_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .flush (flush),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // returns {hi, lo}
   function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      longint sx, sy, q, r;
      logic [63:0] ux, uy, res;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'd0, x};
      uy = {32'd0, y};
      res = '0;
      case (o)
         OP_MULT:  res = sx * sy;
         OP_MULTU: res = ux * uy;
         OP_DIV: begin
            if (y == '0) res = {x, 32'hFFFFFFFF};
            else begin
               q = sx / sy;
               r = sx % sy;
               res = {r[31:0], q[31:0]};
            end
         end
         OP_DIVU: begin
            if (y == '0) res = {x, 32'hFFFFFFFF};
            else res = {32'(ux % uy), 32'(ux / uy)};
         end
         default: res = '0;
      endcase
      return res;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_hi    <= '0;
         m_lo    <= '0;
         p_valid <= 1'b0;
         m_done  <= 1'b0;
         edge_n  <= 0;
      end else begin
         edge_n <= edge_n + 1;
         m_done <= 1'b0;
         if (p_valid) begin
            if (flush) p_valid <= 1'b0;
            else if (edge_n == p_edge) begin
               m_hi    <= p_hi;
               m_lo    <= p_lo;
               p_valid <= 1'b0;
               m_done  <= 1'b1;
            end
         end else if (start && !flush) begin
            if (op_is_iter(op)) begin
               {p_hi, p_lo} <= ref_result(op, a, b);
               p_valid      <= 1'b1;
               p_edge       <= edge_n + W + 2;
            end else if (op == OP_MTHI) begin
               m_hi   <= a;
               m_done <= 1'b1;
            end else if (op == OP_MTLO) begin
               m_lo   <= a;
               m_done <= 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("busy", {63'd0, busy}, {63'd0, p_valid});
         chk("done", {63'd0, done}, {63'd0, m_done});
         chk("hi", {32'd0, hi}, {32'd0, m_hi});
         chk("lo", {32'd0, lo}, {32'd0, m_lo});
      end
   end

   task automatic run_wait(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, output int lat);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y; flush = 1'b0;
      lat = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         start = 1'b0;
         if (done) break;
      end
      chk("done_seen", {63'd0, done}, 64'd1);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 6))
         0: return '0;
         1: return 32'd1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return 32'($urandom_range(0, 20));
         5: return 32'h7FFFFFFF;
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      int lat;
      // reset state
      repeat (2) @(negedge clk);
      chk("reset_busy", {63'd0, busy}, 64'd0);
      chk("reset_done", {63'd0, done}, 64'd0);
      chk("reset_hilo", {hi, lo}, 64'd0);
      rst = 1'b0;

      run_wait(OP_MULT, 32'hFFFFFFFE, 32'd3, lat);
      chk("mult_latency", 64'(lat - 1), 64'd34);
      chk("mult_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);

      // MTLO accepted in the done cycle of the MULT
      start = 1'b1; op = OP_MTLO; a = 32'hA5A5A5A5;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("mtlo_b2b_done", {63'd0, done}, 64'd1);
      chk("mtlo_b2b", {hi, lo}, 64'hFFFFFFFF_A5A5A5A5);

      run_wait(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
      chk("multu_max", {hi, lo}, 64'hFFFFFFFE_00000001);
      run_wait(OP_DIV, 32'hFFFFFFF9, 32'd2, lat);
      chk("div_neg7_2", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
      run_wait(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat);
      chk("div_min_m1", {hi, lo}, 64'h00000000_80000000);
      run_wait(OP_DIVU, 32'h1234, 32'd0, lat);
      chk("divu_zero", {hi, lo}, 64'h00001234_FFFFFFFF);

      // start held with different op/operands while busy is ignored
      @(negedge clk);
      start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
      @(posedge clk);
      @(negedge clk);
      op = OP_MTHI; a = 32'hDEADBEEF; b = 32'd0;
      repeat (5) @(negedge clk);
      start = 1'b0; a = 32'h55; b = 32'h3;
      lat = 0;
      while (!done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk("busy_ignore", {hi, lo}, {32'd2, 32'd14});

      // flush during FIX keeps HI/LO and suppresses done
      @(negedge clk);
      start = 1'b1; op = OP_DIV; a = 32'hFFFFFF9C; b = 32'd7;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (W + 1) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      chk("flush_fix_done", {63'd0, done}, 64'd0);
      chk("flush_fix_busy", {63'd0, busy}, 64'd0);
      chk("flush_fix_hilo", {hi, lo}, {32'd2, 32'd14});

      // asynchronous reset mid-RUN
      @(negedge clk);
      start = 1'b1; op = OP_MULT; a = 32'd9; b = 32'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_busy", {63'd0, busy}, 64'd0);
      chk("rst_mid_done", {63'd0, done}, 64'd0);
      chk("rst_mid_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      #2 rst = 1'b0;
      run_wait(OP_MULTU, 32'd7, 32'd6, lat);
      chk("after_rst", {hi, lo}, 64'd42);

      // randomized traffic, checked every cycle by the compare process
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 1) == 1);
         flush = ($urandom_range(0, 40) == 0);
         op    = 3'($urandom_range(0, 7));
         a     = pick();
         b     = pick();
      end
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      repeat (W + 5) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers. It sits beside the combinational ALU in the execute stage and services MULT, MULTU, DIV, DIVU, MTHI and MTLO. Iterative operations stall the pipeline through `busy` and report completion with a one-cycle `done`. An exception flush aborts an operation in flight without touching HI/LO.

## Interface
- `WIDTH`, 32: operand and HI/LO width. Must be even and ≥ 4.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request, sampled only while `busy`=0
- `op`  in  3  operation code, encodings in the shared package
- `a`  in  WIDTH  source rs: multiplicand, dividend, or MTHI/MTLO data
- `b`  in  WIDTH  source rt: multiplier or divisor
- `flush`  in  1  abort; higher priority than `start`
- `busy`  out  1  iterative operation in progress; pipeline stalls
- `done`  out  1  one-cycle pulse; HI/LO valid with the new result
- `hi`  out  WIDTH  HI register
- `lo`  out  WIDTH  LO register

## Operation
- FSM states: IDLE, PREP, RUN, FIX.
- IDLE to PREP on `start` && !`flush` && op ∈ {MULT, MULTU, DIV, DIVU}.
  - Operands are latched.
  - Signed ops convert operands to magnitude and record the result signs.
- PREP to RUN. RUN performs one shift-add (mul) or restoring-subtract (div) step per cycle. An iteration counter runs from 0 to WIDTH−1.
- RUN to FIX after WIDTH iterations. FIX applies sign correction and writes HI/LO.
- FIX to IDLE, with `done`=1 in the following cycle.
- MTHI/MTLO with `start` in IDLE: `hi`/`lo` are written at that edge. `done` pulses the next cycle. No busy.
- Multiply: {hi,lo} = full 2·WIDTH product.
  - MULT is two's-complement signed.
  - MULTU is unsigned.
- Divide: lo = quotient, hi = remainder.
  - The signed quotient truncates toward zero.
  - The signed remainder takes the sign of the dividend.
- Signed min ÷ −1: lo = min, hi = 0. No trap.
- Divide by zero (DIV or DIVU): lo = all ones, hi = `a`. This is forced in FIX, independent of signs.
- `flush` in any state:
  - Next state is IDLE.
  - `busy` and `done` are 0 the following cycle.
  - HI/LO are unchanged, including a FIX-cycle write, which is suppressed.
  - An MTHI/MTLO request is dropped.
- `start` while `busy`=1 is ignored. The requester holds `start` until `busy` drops.
- `op` values outside the defined set in IDLE are ignored: no state change, no `done`.

## Timing
- Reset, asynchronous: state IDLE, counter 0, `busy`=0, `done`=0, `hi`=0, `lo`=0.
- Reset mid-operation discards everything immediately.
- Iterative latency, with `start` sampled at edge E0:
  - `busy`=1 from after E0 through the cycle ending at E(WIDTH+2).
  - HI/LO update at E(WIDTH+2).
  - `done`=1 for exactly the cycle after E(WIDTH+2).
- Result: WIDTH+2 cycles per mul/div, or 34 at WIDTH=32.
- MTHI/MTLO latency: 1 edge. `done` is high the cycle after E0.
- `busy` and `done` are registered. `hi`/`lo` are registered outputs.
- `done` cycle is IDLE, so a new `start` is accepted back-to-back in that cycle.
- Operands are only read at E0. Changes to `a`/`b` during `busy` have no effect.

## Structure
- Shared package `mdu_pkg` holds:
  - the `op` encodings: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5
  - the FSM state enum
- The unit does not reuse the ALU control encodings.
- Sub-module `mdu_iter_core`: a WIDTH-parametrised magnitude shift-add/restoring-divide datapath.
  - Inputs: step enable, mode (mul/div).
  - Outputs: 2·WIDTH accumulator.
  - The top keeps the FSM, sign handling, special cases, flush and HI/LO.
- Target size: 200–300 lines of RTL total.

## Test plan
All values at WIDTH=32.
- Reset: assert `rst` mid-RUN, then release → `busy`=0, `done`=0, `hi`=`lo`=0 immediately. The next `start` completes normally.
- MULT a=0xFFFFFFFE (−2), b=3 → `done` at cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=−7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV 0x80000000 ÷ −1 → lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234.
- Flush and concurrency:
  - `flush` during FIX of a DIV → HI/LO keep prior values, no `done`.
  - MTLO 0xA5A5A5A5 in the `done` cycle of a MULT → accepted; `lo`=0xA5A5A5A5 next cycle, `hi` keeps the MULT result.
  - `start` during `busy` → ignored.
